// File: rtl/frame_arb_pkg.sv
// rtl/frame_arb_pkg.sv - shared state type, geometry defaults and address-width helper for frame_buffer_arbiter
package frame_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  localparam int DEF_IMG_W       = 160;
  localparam int DEF_IMG_H       = 120;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_PIXEL_W     = 24;
  localparam int DEF_MODE_W      = 2;
  localparam int DEF_COORD_W     = 10;

  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - start key synchroniser, falling-edge detect and post-press lockout
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] lock_cnt;
  logic             accept;

  // Edges seen while the lockout counter is running are dropped, not deferred.
  assign accept = prev & ~sync2 & (lock_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      lock_cnt    <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      prev        <= sync2;
      press_pulse <= accept;
      if (accept) begin
        lock_cnt <= CNT_W'(DEBOUNCE_CYCLES);
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - frame RAM owner shared by VGA read path and filter engine; FRAME_ARB_PENDING_EN queues one start press
module frame_buffer_arbiter
  import frame_arb_pkg::*;
#(
  parameter int IMG_W           = DEF_IMG_W,
  parameter int IMG_H           = DEF_IMG_H,
  parameter int SCALE_SHIFT     = DEF_SCALE_SHIFT,
  parameter int PIXEL_W         = DEF_PIXEL_W,
  parameter int MODE_W          = DEF_MODE_W,
  parameter int COORD_W         = DEF_COORD_W,
  parameter int RD_LAT          = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_TIMEOUT     = 2000000,
  localparam int ADDR_W         = addr_width(IMG_W, IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start_n,
  input  logic [MODE_W-1:0]  mode_sel,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic               frame_done,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [PIXEL_W-1:0] proc_wdata,
  input  logic               proc_we,
  input  logic               proc_done,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0] mem_wdata,
  output logic               mem_we,
  output logic               proc_start,
  output logic [MODE_W-1:0]  proc_mode,
  output logic               proc_grant,
  output logic [PIXEL_W-1:0] disp_pixel,
  output logic               disp_valid,
  output logic               busy,
  output logic               timeout_err
);

  localparam int DISP_W = IMG_W << SCALE_SHIFT;
  localparam int DISP_H = IMG_H << SCALE_SHIFT;
  localparam int WD_W   = $clog2(RUN_TIMEOUT + 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              press;
  logic [MODE_W-1:0] mode_q;
  logic              err_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expired;
  logic              take_start;
  logic [MODE_W-1:0] start_mode;
  logic [RD_LAT-1:0] vpipe;
  logic              in_area;
  logic [ADDR_W-1:0] disp_addr;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_start_n),
    .press_pulse(press)
  );

  // Full-width compare so coordinates past the display area never alias back in.
  assign in_area   = (32'(x_pos) < DISP_W) && (32'(y_pos) < DISP_H);
  assign disp_addr = ADDR_W'(y_pos >> SCALE_SHIFT)
                   + ADDR_W'(x_pos >> SCALE_SHIFT) * ADDR_W'(IMG_H);
  assign wd_expired = (wd_cnt == WD_W'(RUN_TIMEOUT - 1));

`ifdef FRAME_ARB_PENDING_EN
  logic              pend_q;
  logic [MODE_W-1:0] pend_mode_q;
  logic              pend_capture;

  // A press that cannot start a run right now is parked, newest mode wins.
  assign pend_capture = press && !(state == IDLE && !pend_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_mode_q <= '0;
    end else if (pend_capture) begin
      pend_q      <= 1'b1;
      pend_mode_q <= mode_sel;
    end else if (take_start && pend_q) begin
      pend_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_next = state;
    take_start = 1'b0;
    start_mode = mode_sel;
    case (state)
      IDLE: begin
`ifdef FRAME_ARB_PENDING_EN
        if (pend_q) begin
          state_next = START;
          take_start = 1'b1;
          start_mode = pend_mode_q;
        end else
`endif
        if (press) begin
          state_next = START;
          take_start = 1'b1;
        end
      end
      START: state_next = RUN;
      RUN: begin
        if (proc_done || wd_expired) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (frame_done) begin
          state_next = IDLE;
`ifdef FRAME_ARB_PENDING_EN
          if (pend_q) begin
            state_next = START;
            take_start = 1'b1;
            start_mode = pend_mode_q;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A completion arriving on the expiry cycle wins over the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      err_q  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      if (take_start) begin
        mode_q <= start_mode;
        err_q  <= 1'b0;
      end else if (state == RUN && !proc_done && wd_expired) begin
        err_q <= 1'b1;
      end
      if (state == RUN) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // Flushing outside IDLE squashes reads issued before the RAM changed hands.
  always_ff @(posedge clk) begin
    if (rst || state != IDLE) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_area;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    proc_start  = 1'b0;
    proc_grant  = 1'b0;
    proc_mode   = '0;
    disp_pixel  = '0;
    disp_valid  = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    if (!rst) begin
      proc_mode   = mode_q;
      timeout_err = err_q;
      busy        = (state != IDLE);
      case (state)
        IDLE: begin
          if (in_area) begin
            mem_addr = disp_addr;
          end
          disp_valid = vpipe[RD_LAT-1];
          if (vpipe[RD_LAT-1]) begin
            disp_pixel = mem_rdata;
          end
        end
        START: begin
          proc_start = 1'b1;
          proc_grant = 1'b1;
          mem_addr   = proc_addr;
        end
        RUN: begin
          proc_grant = 1'b1;
          mem_addr   = proc_addr;
          mem_wdata  = proc_wdata;
          mem_we     = proc_we;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - randomized bench for frame_buffer_arbiter against a behavioural model
module tb_frame_buffer_arbiter;

  localparam int IW = 160, IH = 120, SS = 2, PW = 24, MW = 2, CW = 10;
  localparam int RL = 2, DEB = 100, TO = 50;
  localparam int NPIX = IW * IH;
  localparam int AW = $clog2(NPIX);
  localparam int DW = IW << SS, DH = IH << SS;
  localparam int PH_IDLE = 0, PH_START = 1, PH_RUN = 2, PH_HOLD = 3;

  logic clk = 1'b0, rst = 1'b1, key_start_n = 1'b1;
  logic [MW-1:0] mode_sel = '0;
  logic [CW-1:0] x_pos = '0, y_pos = '0;
  logic frame_done = 1'b0, proc_we = 1'b0, proc_done = 1'b0;
  logic [AW-1:0] proc_addr = '0;
  logic [PW-1:0] proc_wdata = '0;
  logic [PW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_wdata, disp_pixel;
  logic mem_we, proc_start, proc_grant, disp_valid, busy, timeout_err;
  logic [MW-1:0] proc_mode;

  int errors = 0, checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  frame_buffer_arbiter #(
    .IMG_W(IW), .IMG_H(IH), .SCALE_SHIFT(SS), .PIXEL_W(PW), .MODE_W(MW),
    .COORD_W(CW), .RD_LAT(RL), .DEBOUNCE_CYCLES(DEB), .RUN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .key_start_n(key_start_n), .mode_sel(mode_sel),
    .x_pos(x_pos), .y_pos(y_pos), .frame_done(frame_done),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_we(proc_we),
    .proc_done(proc_done), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .proc_start(proc_start),
    .proc_mode(proc_mode), .proc_grant(proc_grant), .disp_pixel(disp_pixel),
    .disp_valid(disp_valid), .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [PW-1:0] pat(input int i);
    return PW'(32'h00A5_0000 ^ (i * 3));
  endfunction

  // Frame RAM with RL-cycle read latency
  logic [PW-1:0] ram [NPIX];
  logic [PW-1:0] rpipe [RL];
  assign mem_rdata = rpipe[RL-1];
  always @(posedge clk) begin
    rpipe[0] <= ram[mem_addr];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Behavioural model
  logic [PW-1:0] sram [NPIX];
  int m_ph, m_lock, m_age;
  bit m_pulse, m_err;
  logic [MW-1:0] m_mode;
  bit kh [3];
  bit dv [RL];
  logic [PW-1:0] dp [RL];

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ram[i] = pat(i);
      sram[i] = pat(i);
    end
  end

  function automatic bit area(input int x, input int y);
    return (x < DW) && (y < DH);
  endfunction

  function automatic int daddr(input int x, input int y);
    return (y >> SS) + (x >> SS) * IH;
  endfunction

  always @(posedge clk) begin
    bit acc, nv;
    logic [PW-1:0] np;
    if (rst) begin
      m_ph = PH_IDLE; m_lock = 0; m_age = 0; m_pulse = 0; m_err = 0; m_mode = '0;
      kh[0] = 1; kh[1] = 1; kh[2] = 1;
      for (int i = 0; i < RL; i++) begin dv[i] = 0; dp[i] = '0; end
    end else begin
      acc = kh[2] && !kh[1] && (m_lock == 0);
      nv = (m_ph == PH_IDLE) && area(int'(x_pos), int'(y_pos));
      np = nv ? sram[daddr(int'(x_pos), int'(y_pos))] : '0;
      if (m_ph == PH_IDLE) begin
        for (int i = RL - 1; i > 0; i--) begin dv[i] = dv[i-1]; dp[i] = dp[i-1]; end
        dv[0] = nv; dp[0] = np;
      end else begin
        for (int i = 0; i < RL; i++) begin dv[i] = 0; dp[i] = '0; end
      end
      case (m_ph)
        PH_IDLE: if (m_pulse) begin m_ph = PH_START; m_mode = mode_sel; m_err = 0; end
        PH_START: begin m_ph = PH_RUN; m_age = 0; end
        PH_RUN: begin
          if (proc_we) sram[proc_addr] = proc_wdata;
          m_age++;
          if (proc_done) m_ph = PH_HOLD;
          else if (m_age == TO) begin m_err = 1; m_ph = PH_HOLD; end
        end
        default: if (frame_done) m_ph = PH_IDLE;
      endcase
      if (acc) m_lock = DEB;
      else if (m_lock > 0) m_lock--;
      m_pulse = acc;
      kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = key_start_n;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_wd, e_px;
    logic e_we, e_st, e_gr, e_dv, e_busy, e_err;
    logic [MW-1:0] e_mode;
    if (cmp_en) begin
      e_addr = '0; e_wd = '0; e_px = '0; e_we = 0; e_st = 0; e_gr = 0;
      e_dv = 0; e_busy = 0; e_err = 0; e_mode = '0;
      if (!rst) begin
        e_mode = m_mode; e_err = m_err; e_busy = (m_ph != PH_IDLE);
        case (m_ph)
          PH_IDLE: begin
            if (area(int'(x_pos), int'(y_pos))) e_addr = AW'(daddr(int'(x_pos), int'(y_pos)));
            e_dv = dv[RL-1];
            e_px = dv[RL-1] ? dp[RL-1] : '0;
          end
          PH_START: begin e_st = 1; e_gr = 1; e_addr = proc_addr; end
          PH_RUN: begin e_gr = 1; e_addr = proc_addr; e_wd = proc_wdata; e_we = proc_we; end
          default: ;
        endcase
      end
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("proc_start", 64'(proc_start), 64'(e_st));
      chk("proc_grant", 64'(proc_grant), 64'(e_gr));
      chk("proc_mode", 64'(proc_mode), 64'(e_mode));
      chk("disp_valid", 64'(disp_valid), 64'(e_dv));
      chk("disp_pixel", 64'(disp_pixel), 64'(e_px));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("timeout_err", 64'(timeout_err), 64'(e_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_proc(input int amax);
    proc_addr = AW'($urandom_range(0, amax));
    proc_wdata = PW'($urandom);
    proc_we = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_xy(input int xmax, input int ymax);
    x_pos = CW'($urandom_range(0, xmax));
    y_pos = CW'($urandom_range(0, ymax));
  endtask

  initial begin
    int first, n_start, t_start, t_err;
    rst = 1; x_pos = 7; y_pos = 9;
    step(); cmp_en = 1; step(); step();
    #1 chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 0;
    #1 chk("addr_7_9", 64'(mem_addr), 122);
    repeat (RL) step();
    #1 chk("dv_7_9", 64'(disp_valid), 1);
    chk("px_7_9", 64'(disp_pixel), 64'h00A5016E);
    x_pos = 640; y_pos = 0;
    #1 chk("addr_640_0", 64'(mem_addr), 0);
    repeat (RL) step();
    #1 chk("dv_640_0", 64'(disp_valid), 0);
    x_pos = 639; y_pos = 479;
    #1 chk("addr_639_479", 64'(mem_addr), 19199);

    for (int i = 0; i < 150; i++) begin
      step();
      rand_xy(700, 520); rand_proc(NPIX - 1);
      proc_done = 1'($urandom_range(0, 1)); frame_done = 1'($urandom_range(0, 1));
    end

    // Press with a bounce inside the lockout window
    step();
    proc_done = 0; frame_done = 0; proc_we = 0; mode_sel = 2;
    key_start_n = 0; first = -1; n_start = 0;
    for (int i = 1; i <= 40; i++) begin
      step(); #1;
      if (proc_start) begin n_start++; if (first < 0) first = i; end
      if (i == 3) key_start_n = 1;
      if (i == 10) key_start_n = 0;
      if (i == 14) key_start_n = 1;
      if (i >= 5) mode_sel = MW'($urandom);
      rand_proc(359); rand_xy(700, 520);
    end
    chk("start_latency", 64'(first), 4);
    chk("mode_latched", 64'(proc_mode), 2);
    proc_done = 1;
    step(); #1;
    proc_done = 0;
    for (int i = 0; i < 10; i++) begin
      rand_proc(359);
      step(); #1;
      if (proc_start) n_start++;
    end
    chk("hold_busy", 64'(busy), 1);
    chk("hold_grant", 64'(proc_grant), 0);
    frame_done = 1;
    step(); #1;
    frame_done = 0;
    chk("back_idle", 64'(busy), 0);
    chk("single_start", 64'(n_start), 1);

    for (int i = 0; i < 200; i++) begin
      step(); rand_xy(15, 479);
    end

    // Watchdog: no completion ever arrives
    mode_sel = 1; key_start_n = 0; t_start = -1; t_err = -1;
    for (int i = 1; i <= 70; i++) begin
      step(); #1;
      if (proc_start && t_start < 0) t_start = i;
      if (timeout_err && t_err < 0) t_err = i;
      if (i == 3) key_start_n = 1;
      rand_proc(NPIX - 1); rand_xy(700, 520);
    end
    chk("timeout_seen", 64'(t_err > 0), 1);
    chk("timeout_latency", 64'(t_err - t_start), 51);
    chk("timeout_hold", 64'(busy && !proc_grant), 1);
    frame_done = 1;
    step(); #1;
    frame_done = 0;
    chk("timeout_idle", 64'(busy), 0);
    chk("timeout_sticky", 64'(timeout_err), 1);

    for (int i = 0; i < 110; i++) begin
      step(); rand_xy(700, 520);
    end

    // Reset in the middle of a run while a write is requested
    mode_sel = 3; key_start_n = 0; proc_we = 0;
    for (int i = 1; i <= 20 && !(busy && proc_grant && !proc_start); i++) begin
      step(); #1;
      if (i == 3) key_start_n = 1;
    end
    chk("run_reached", 64'(busy && proc_grant && !proc_start), 1);
    chk("err_cleared", 64'(timeout_err), 0);
    key_start_n = 1; proc_we = 1; proc_addr = 5; proc_wdata = 24'h123456; rst = 1;
    #1 chk("rst_we", 64'(mem_we), 0);
    chk("rst_grant", 64'(proc_grant), 0);
    step(); #1;
    chk("rst_idle", 64'(busy), 0);
    chk("rst_mode", 64'(proc_mode), 0);
    rst = 0; proc_we = 0;

    for (int i = 0; i < 1500; i++) begin
      step();
      rand_xy(700, 520); rand_proc(NPIX - 1);
      mode_sel = MW'($urandom);
      proc_done = ($urandom_range(0, 39) == 0);
      frame_done = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 24) == 0) key_start_n = ~key_start_n;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 0;
    step(); step();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
